// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard command/response codes and sequencer state types.
package ps2_pkg;

    // Host-to-keyboard commands
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;

    // Keyboard-to-host responses
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_ERROR
    } state_e;

    // Which byte of a command sequence is currently in flight
    typedef enum logic [1:0] {
        STEP_RESET,
        STEP_LED_CMD,
        STEP_LED_ARG
    } step_e;

    // Byte transmitted for a given step; the LED argument carries the mask.
    function automatic logic [7:0] step_byte(input step_e step, input logic [2:0] mask);
        case (step)
            STEP_RESET:   return CMD_RESET;
            STEP_LED_CMD: return CMD_SET_LED;
            default:      return {5'b0, mask};
        endcase
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Cycle counter that flags expiry when it reaches a programmable limit.
// Holds at the limit until cleared so expired stays asserted while enabled.
module ps2_timeout_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == limit);

    // Next count: clear wins, otherwise count up while enabled and not at limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 keyboard command sequencer: runs the reset/BAT/LED init sequence and
// LED updates with ACK/resend/timeout handling; forwards scan codes when idle.
module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int BAT_TIMEOUT = 37_500_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_done,
    output logic [7:0] key_data,
    output logic       key_en,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TW = $clog2(BAT_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_e         state_q, state_d;
    step_e          step_q, step_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [2:0]     mask_q, mask_d;
    logic           pend_init_q, pend_init_d;
    logic           pend_led_q, pend_led_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [7:0]     key_data_q, key_data_d;
    logic           key_en_q, key_en_d;

    logic           start;
    logic           do_retry;
    logic           do_error;

    logic           timer_clear;
    logic           timer_en;
    logic [TW-1:0]  timer_limit;
    logic           timer_expired;

    // The timer restarts whenever the FSM changes state, so every wait
    // state begins counting from zero.
    assign timer_clear = (state_d != state_q);
    assign timer_en    = (state_q == ST_WAIT_TX) || (state_q == ST_WAIT_ACK) ||
                         (state_q == ST_WAIT_BAT);
    assign timer_limit = (state_q == ST_WAIT_BAT) ? TW'(BAT_TIMEOUT) : TW'(ACK_TIMEOUT);

    ps2_timeout_timer #(
        .W (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    assign tx_data  = tx_data_q;
    assign tx_send  = (state_q == ST_SEND);
    assign key_data = key_data_q;
    assign key_en   = key_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

    // Next-state, request bookkeeping and registered output values
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        mask_d      = mask_q;
        pend_init_d = pend_init_q;
        pend_led_d  = pend_led_q;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        key_data_d  = key_data_q;
        key_en_d    = 1'b0;
        start       = 1'b0;
        do_retry    = 1'b0;
        do_error    = 1'b0;

        // Requests arriving outside IDLE are queued; the newest LED mask wins
        if (state_q != ST_IDLE) begin
            if (led_req) begin
                pend_led_d = 1'b1;
                mask_d     = led_mask;
            end
            if (init_req) begin
                pend_init_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (received_data_en) begin
                    key_data_d = received_data;
                    key_en_d   = 1'b1;
                end
                // Init (new or pending) beats LED; a coincident led_req only
                // supplies the mask for the init's trailing LED phase.
                if (init_req || pend_init_q) begin
                    start       = 1'b1;
                    step_d      = STEP_RESET;
                    pend_init_d = 1'b0;
                    if (led_req) mask_d = led_mask;
                end else if (led_req || pend_led_q) begin
                    start      = 1'b1;
                    step_d     = STEP_LED_CMD;
                    pend_led_d = 1'b0;
                    if (led_req) mask_d = led_mask;
                end
                if (start) begin
                    state_d   = ST_SEND;
                    retry_d   = '0;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    tx_data_d = step_byte(step_d, mask_d);
                end
            end

            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_WAIT_ACK;
                end else if (timer_expired) begin
                    do_retry = 1'b1;
                end
            end

            ST_WAIT_ACK: begin
                if (received_data_en && received_data == RSP_ACK) begin
                    retry_d = '0;
                    case (step_q)
                        STEP_RESET: begin
                            state_d = ST_WAIT_BAT;
                        end
                        STEP_LED_CMD: begin
                            step_d    = STEP_LED_ARG;
                            state_d   = ST_SEND;
                            tx_data_d = step_byte(STEP_LED_ARG, mask_d);
                        end
                        default: begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    endcase
                end else if (received_data_en && received_data == RSP_RESEND) begin
                    do_retry = 1'b1;
                end else if (!received_data_en && timer_expired) begin
                    do_retry = 1'b1;
                end
            end

            ST_WAIT_BAT: begin
                if (received_data_en && received_data == RSP_BAT_OK) begin
                    step_d    = STEP_LED_CMD;
                    state_d   = ST_SEND;
                    retry_d   = '0;
                    tx_data_d = step_byte(STEP_LED_CMD, mask_d);
                end else if (received_data_en && received_data == RSP_BAT_FAIL) begin
                    do_error = 1'b1;
                end else if (!received_data_en && timer_expired) begin
                    do_error = 1'b1;
                end
            end

            ST_ERROR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Resend the same byte until the retry budget is spent
        if (do_retry) begin
            if (retry_q >= RW'(MAX_RETRY)) begin
                do_error = 1'b1;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = ST_SEND;
            end
        end

        // Error drops busy immediately and leaves the sticky flag set
        if (do_error) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_RESET;
            retry_q     <= '0;
            mask_q      <= 3'b000;
            pend_init_q <= 1'b0;
            pend_led_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            key_data_q  <= 8'h00;
            key_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            mask_q      <= mask_d;
            pend_init_q <= pend_init_d;
            pend_led_q  <= pend_led_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            key_data_q  <= key_data_d;
            key_en_q    <= key_en_d;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer: a scripted keyboard responder with
// random timing, expected byte streams built from the command protocol.
module tb_ps2_cmd_sequencer;

    localparam int ACK_TO = 100;
    localparam int BAT_TO = 300;
    localparam int MAXR   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_req = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_mask = 3'b000;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [7:0] key_data;
    logic       key_en;
    logic       busy;
    logic       done;
    logic       error;

    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    logic [7:0] tx_log[$];
    logic [2:0] model_mask = 3'b000;

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT (ACK_TO),
        .BAT_TIMEOUT (BAT_TO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .init_req         (init_req),
        .led_req          (led_req),
        .led_mask         (led_mask),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .tx_data          (tx_data),
        .tx_send          (tx_send),
        .tx_done          (tx_done),
        .key_data         (key_data),
        .key_en           (key_en),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    // Record every transmitted byte and every done pulse
    always @(posedge clk) begin
        if (tx_send) tx_log.push_back(tx_data);
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge clk);
        received_data_en = 1'b0;
    endtask

    task automatic req_led(input logic [2:0] m);
        led_mask = m;
        led_req  = 1'b1;
        @(negedge clk);
        led_req    = 1'b0;
        model_mask = m;
    endtask

    task automatic req_init();
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    task automatic req_both(input logic [2:0] m);
        led_mask = m;
        init_req = 1'b1;
        led_req  = 1'b1;
        @(negedge clk);
        init_req   = 1'b0;
        led_req    = 1'b0;
        model_mask = m;
    endtask

    // Keyboard side of one byte: wait for tx_send, finish the transfer, reply
    task automatic serve(input bit has_reply, input logic [7:0] reply, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_send) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        @(negedge clk);
        tick($urandom_range(0, 3));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (has_reply) begin
            tick($urandom_range(0, 6));
            pulse_byte(reply);
        end
    endtask

    task automatic wait_not_busy(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_chk++;
        if ({tx_data, tx_send, key_data, key_en, busy, done, error} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", {tx_data, tx_send, key_data, key_en, busy, done, error});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_idle_forward();
        int base;
        logic [7:0] b;
        base = tx_log.size();
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            received_data    = b;
            received_data_en = 1'b1;
            n_chk++;
            if (key_en !== 1'b0) begin
                n_fail++;
                $display("FAIL fwd_early key_en got %b want 0", key_en);
            end
            @(negedge clk);
            received_data_en = 1'b0;
            n_chk++;
            if (key_en !== 1'b1 || key_data !== b) begin
                n_fail++;
                $display("FAIL fwd_byte got en=%b data=%h want en=1 data=%h", key_en, key_data, b);
            end
            tick($urandom_range(1, 3));
        end
        // stray tx_done while idle must not start anything
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        tick(3);
        n_chk++;
        if (busy !== 1'b0 || tx_log.size() != base) begin
            n_fail++;
            $display("FAIL idle_txdone got busy=%b sends=%0d want busy=0 sends=0", busy, tx_log.size() - base);
        end
    endtask

    task automatic test_led(input logic [2:0] m);
        int base, d0;
        bit ok1, ok2, okw;
        base = tx_log.size();
        d0   = done_cnt;
        req_led(m);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL led_busy_rise got %b want 1", busy);
        end
        serve(1'b1, 8'hFA, ok1);
        serve(1'b1, 8'hFA, ok2);
        wait_not_busy(100, okw);
        n_chk++;
        if (!(ok1 && ok2 && okw) || done !== 1'b1) begin
            n_fail++;
            $display("FAIL led_done_at_busy_fall got ok=%b%b%b done=%b want ok=111 done=1", ok1, ok2, okw, done);
        end
        tick(2);
        n_chk++;
        if (tx_log.size() != base + 2 || tx_log[base] !== 8'hED || tx_log[base+1] !== {5'b0, model_mask}) begin
            n_fail++;
            $display("FAIL led_bytes got n=%0d want ED %h", tx_log.size() - base, {5'b0, model_mask});
        end
        n_chk++;
        if (done_cnt - d0 != 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL led_status got dones=%0d error=%b want 1 0", done_cnt - d0, error);
        end
    endtask

    task automatic test_init();
        int base, d0;
        bit ok1, ok2, ok3, okw;
        logic [2:0] m;
        logic [7:0] exp_b[3];
        m = 3'($urandom);
        base = tx_log.size();
        d0   = done_cnt;
        req_both(m);
        exp_b[0] = 8'hFF;
        exp_b[1] = 8'hED;
        exp_b[2] = {5'b0, model_mask};
        serve(1'b0, 8'h00, ok1);
        tick(2);
        pulse_byte(8'h12);            // ignored while waiting for ACK
        pulse_byte(8'hFA);
        tick($urandom_range(1, 20));
        pulse_byte(8'h55);            // ignored while waiting for BAT
        pulse_byte(8'hAA);
        serve(1'b1, 8'hFA, ok2);
        serve(1'b1, 8'hFA, ok3);
        wait_not_busy(100, okw);
        tick(3);
        n_chk++;
        if (!(ok1 && ok2 && ok3 && okw) || tx_log.size() != base + 3) begin
            n_fail++;
            $display("FAIL init_count got sends=%0d ok=%b%b%b%b want 3 1111", tx_log.size() - base, ok1, ok2, ok3, okw);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (tx_log[base+i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL init_byte%0d got %h want %h", i, tx_log[base+i], exp_b[i]);
                end
            end
        end
        n_chk++;
        if (done_cnt - d0 != 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done got dones=%0d error=%b want 1 0", done_cnt - d0, error);
        end
    endtask

    task automatic test_resend();
        int base, d0;
        bit ok1, ok2, ok3, ok4, okw;
        logic [2:0] m;
        m = 3'($urandom);
        base = tx_log.size();
        d0   = done_cnt;
        req_led(m);
        serve(1'b1, 8'hFE, ok1);
        serve(1'b1, 8'hFE, ok2);
        serve(1'b1, 8'hFA, ok3);
        serve(1'b1, 8'hFA, ok4);
        wait_not_busy(100, okw);
        tick(2);
        n_chk++;
        if (!(ok1 && ok2 && ok3 && ok4 && okw) || tx_log.size() != base + 4 ||
            tx_log[base] !== 8'hED || tx_log[base+1] !== 8'hED || tx_log[base+2] !== 8'hED ||
            tx_log[base+3] !== {5'b0, model_mask}) begin
            n_fail++;
            $display("FAIL resend_bytes got sends=%0d want ED ED ED %h", tx_log.size() - base, {5'b0, model_mask});
        end
        n_chk++;
        if (done_cnt - d0 != 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL resend_done got dones=%0d error=%b want 1 0", done_cnt - d0, error);
        end
    endtask

    task automatic test_pending();
        int base, d0;
        bit ok[6];
        bit okw;
        logic [7:0] exp_b[5];
        base = tx_log.size();
        d0   = done_cnt;
        req_init();
        serve(1'b0, 8'h00, ok[0]);
        req_led(3'b001);
        tick(2);
        req_led(3'b100);
        pulse_byte(8'hFA);
        tick($urandom_range(1, 10));
        pulse_byte(8'hAA);
        serve(1'b1, 8'hFA, ok[1]);
        serve(1'b1, 8'hFA, ok[2]);
        serve(1'b1, 8'hFA, ok[3]);
        serve(1'b1, 8'hFA, ok[4]);
        wait_not_busy(100, okw);
        tick(30);
        exp_b[0] = 8'hFF;
        exp_b[1] = 8'hED;
        exp_b[2] = 8'h04;
        exp_b[3] = 8'hED;
        exp_b[4] = 8'h04;
        n_chk++;
        if (!(ok[0] && ok[1] && ok[2] && ok[3] && ok[4] && okw) || tx_log.size() != base + 5) begin
            n_fail++;
            $display("FAIL pend_count got sends=%0d want 5", tx_log.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (tx_log[base+i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL pend_byte%0d got %h want %h", i, tx_log[base+i], exp_b[i]);
                end
            end
        end
        n_chk++;
        if (done_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL pend_dones got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int base, d0;
        bit ok[4];
        bit okw, all_ok;
        base = tx_log.size();
        d0   = done_cnt;
        req_led(3'($urandom));
        all_ok = 1'b1;
        for (int i = 0; i < 1 + MAXR; i++) begin
            serve(1'b0, 8'h00, ok[i]);
            all_ok = all_ok && ok[i];
        end
        wait_not_busy(300, okw);
        n_chk++;
        if (!(all_ok && okw) || error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_error got ok=%b error=%b busy=%b want 1 1 0", all_ok && okw, error, busy);
        end
        tick(200);
        n_chk++;
        if (tx_log.size() != base + 1 + MAXR) begin
            n_fail++;
            $display("FAIL timeout_sends got %0d want %0d", tx_log.size() - base, 1 + MAXR);
        end else begin
            for (int i = 0; i < 1 + MAXR; i++) begin
                n_chk++;
                if (tx_log[base+i] !== 8'hED) begin
                    n_fail++;
                    $display("FAIL timeout_byte%0d got %h want ED", i, tx_log[base+i]);
                end
            end
        end
        n_chk++;
        if (done_cnt != d0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky got dones=%0d error=%b want 0 1", done_cnt - d0, error);
        end
    endtask

    task automatic test_bat_fail();
        int base, d0;
        bit ok1, okw;
        base = tx_log.size();
        d0   = done_cnt;
        req_init();
        n_chk++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bat_accept got error=%b busy=%b want 0 1", error, busy);
        end
        serve(1'b1, 8'hFA, ok1);
        tick($urandom_range(1, 10));
        pulse_byte(8'hFC);
        wait_not_busy(20, okw);
        tick(3);
        n_chk++;
        if (!(ok1 && okw) || error !== 1'b1 || done_cnt != d0 || tx_log.size() != base + 1) begin
            n_fail++;
            $display("FAIL bat_fc got error=%b dones=%0d sends=%0d want 1 0 1", error, done_cnt - d0, tx_log.size() - base);
        end
    endtask

    task automatic test_bat_timeout();
        int base, d0;
        bit ok1, okw;
        base = tx_log.size();
        d0   = done_cnt;
        req_init();
        serve(1'b1, 8'hFA, ok1);
        tick(BAT_TO / 2);
        n_chk++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL bat_wait got busy=%b error=%b want 1 0", busy, error);
        end
        wait_not_busy(BAT_TO, okw);
        tick(3);
        n_chk++;
        if (!(ok1 && okw) || error !== 1'b1 || done_cnt != d0 || tx_log.size() != base + 1) begin
            n_fail++;
            $display("FAIL bat_timeout got error=%b dones=%0d sends=%0d want 1 0 1", error, done_cnt - d0, tx_log.size() - base);
        end
    endtask

    task automatic test_rst_mid();
        int base;
        bit ok1;
        req_led(3'($urandom));
        serve(1'b0, 8'h00, ok1);
        tick(3);
        base = tx_log.size();
        rst     = 1'b1;
        led_req = 1'b1;               // request alongside reset is dropped
        @(negedge clk);
        n_chk++;
        if (!ok1 || {tx_data, tx_send, key_data, key_en, busy, done, error} !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got %h want 0", {tx_data, tx_send, key_data, key_en, busy, done, error});
        end
        rst     = 1'b0;
        led_req = 1'b0;
        tick(5);
        n_chk++;
        if (busy !== 1'b0 || tx_log.size() != base) begin
            n_fail++;
            $display("FAIL rst_mid_abort got busy=%b sends=%0d want 0 0", busy, tx_log.size() - base);
        end
        received_data    = 8'h1C;
        received_data_en = 1'b1;
        @(negedge clk);
        received_data_en = 1'b0;
        n_chk++;
        if (key_en !== 1'b1 || key_data !== 8'h1C) begin
            n_fail++;
            $display("FAIL rst_mid_fwd got en=%b data=%h want 1 1c", key_en, key_data);
        end
        @(negedge clk);
        n_chk++;
        if (key_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_fwd_pulse got en=%b want 0", key_en);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle_forward();
        test_led(3'b101);
        test_led(3'($urandom));
        test_led(3'($urandom));
        test_init();
        test_resend();
        test_pending();
        test_timeout();
        test_bat_fail();
        test_bat_timeout();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 1_000_000, max cycles to wait for tx_done or a reply byte (20 ms @ 50 MHz).
REQ-002 SHALL have parameter BAT_TIMEOUT, default 37_500_000, max cycles to wait for the BAT result after reset ACK (750 ms @ 50 MHz).
REQ-003 SHALL have parameter MAX_RETRY, default 3, number of resends allowed per byte before error.
REQ-004 SHALL have ports, one clock, reset synchronous active-high:
 clk  in  1  system clock, all logic on posedge
 rst  in  1  synchronous active-high reset
 init_req  in  1  pulse: run keyboard reset/init sequence
 led_req  in  1  pulse: update keyboard LEDs
 led_mask  in  3  {caps, num, scroll}, sampled when led_req is accepted
 received_data  in  8  byte from PS/2 receiver
 received_data_en  in  1  one-cycle strobe, received_data valid
 tx_data  out  8  byte to PS/2 transmitter
 tx_send  out  1  one-cycle pulse, start transmit
 tx_done  in  1  one-cycle pulse, transmit finished
 key_data  out  8  forwarded scan code
 key_en  out  1  one-cycle strobe, key_data valid
 busy  out  1  high while any sequence runs
 done  out  1  one-cycle pulse, sequence completed OK
 error  out  1  sticky failure flag

Function
REQ-005 SHALL implement states IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, ERROR.
REQ-006 Init sequence SHALL be: send 0xFF, expect 0xFA, expect 0xAA in WAIT_BAT, then run the LED sequence with the latched mask.
REQ-007 LED sequence SHALL be: send 0xED, expect 0xFA, send {5'b0, mask}, expect 0xFA.
REQ-008 SEND SHALL drive tx_data and pulse tx_send for exactly one cycle, then enter WAIT_TX.
REQ-009 WAIT_TX SHALL go to WAIT_ACK on tx_done; a timeout counts as a retry.
REQ-010 In WAIT_ACK, 0xFA SHALL advance the sequence.
REQ-011 In WAIT_ACK, 0xFE SHALL resend the same byte and increment the retry count.
REQ-012 In WAIT_ACK, any other byte SHALL be ignored.
REQ-013 In WAIT_ACK, expiry of ACK_TIMEOUT SHALL resend the same byte and increment the retry count.
REQ-014 In WAIT_BAT, 0xAA SHALL advance, 0xFC SHALL go to ERROR, and expiry of BAT_TIMEOUT SHALL go to ERROR with no retry.
REQ-015 When the retry count exceeds MAX_RETRY, the FSM SHALL go to ERROR.
REQ-016 The retry count SHALL clear on every accepted ACK.
REQ-017 The timeout timer SHALL clear on entry to each wait state; its width SHALL be clog2(BAT_TIMEOUT+1).
REQ-018 A timeout SHALL fire in the cycle the timer equals the limit.
REQ-019 ERROR SHALL set error, drop busy and return to IDLE next cycle.
REQ-020 error SHALL stay set until the next accepted init_req or led_req.
REQ-021 Successful completion SHALL pulse done one cycle in the same cycle busy falls.
REQ-022 busy SHALL rise the cycle after a request is accepted.
REQ-023 If init_req and led_req coincide in IDLE, init SHALL win; the led_req mask SHALL be latched and used by the trailing LED phase.
REQ-024 led_req while busy SHALL set a pending flag and overwrite the latched mask (latest wins); the pending LED sequence SHALL start the cycle after the current one completes or errors.
REQ-025 init_req while busy SHALL set a pending init, which has priority over a pending LED request.
REQ-026 In IDLE, a received_data_en byte SHALL be forwarded: key_data = byte, key_en pulsed one cycle later.
REQ-027 While busy, received bytes SHALL be consumed by the FSM and never forwarded.
REQ-028 tx_done outside WAIT_TX SHALL be ignored.

Reset
REQ-029 On rst the FSM SHALL enter IDLE and clear timer, retry count, pending flags and latched mask.
REQ-030 On rst outputs SHALL be: tx_data=0x00, tx_send=0, key_data=0x00, key_en=0, busy=0, done=0, error=0.
REQ-031 rst mid-sequence SHALL abort with no tx_send in the cycle after reset.
REQ-032 A request asserted together with rst SHALL be dropped.

Structure
REQ-033 A shared package ps2_pkg SHALL hold command/response constants (0xFF, 0xED, 0xFA, 0xFE, 0xAA, 0xFC) and the state enum.
REQ-034 The timeout timer SHALL be a sub-module ps2_timeout_timer (clear, enable, limit in, expired out).

Verification
REQ-035 Bench SHALL cover: led_req mask=3'b101, replies FA, FA -> tx bytes 0xED then 0x05, done pulse, error=0.
REQ-036 Bench SHALL cover: init_req, replies FA, AA, FA, FA -> tx 0xFF, 0xED, {5'b0, mask}; exactly one done.
REQ-037 Bench SHALL cover: led_req, reply FE twice then FA -> 0xED sent 3 times, sequence completes.
REQ-038 Bench SHALL cover: led_req with no replies, ACK_TIMEOUT=100 -> 0xED sent 1+MAX_RETRY times, then error=1, busy=0, no done.
REQ-039 Bench SHALL cover: led_req(3'b001) during init, then led_req(3'b100) -> one extra LED sequence after init, sending 0x04.
REQ-040 Bench SHALL cover: rst asserted in WAIT_ACK -> all outputs at reset values; a following idle byte 0x1C appears on key_data with key_en one cycle later.
